fft_bfly_sched: RTL and testbench

//  Sequencer for an in-place iterative radix-2 DIT FFT built around one shared

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_addr_gen.sv | 30 +++
 rtl/fft_bfly_sched.sv | 172 +++++++++++++++++
 tb/tb_fft_bfly_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and address helper for the radix-2 DIT FFT butterfly scheduler.
// Holds the FSM state enum and the (stage, butterfly) -> {addr_a, addr_b, k} mapping.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] k;
  } bfly_addr_t;

  // span = 2^s; the butterfly index splits into group (high bits) and
  // position within group (low s bits). Shifts only.
  function automatic bfly_addr_t bfly_addr(
    input logic [31:0] logn,
    input logic [31:0] s,
    input logic [31:0] b
  );
    bfly_addr_t r;
    logic [31:0] span;
    logic [31:0] pos;
    logic [31:0] grp;
    span = 32'd1 << s;
    pos  = b & (span - 32'd1);
    grp  = b >> s;
    r.a  = (grp << (s + 32'd1)) | pos;
    r.b  = r.a | span;
    r.k  = pos << (logn - 32'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address / twiddle generator.
// Ports: s (stage), b (butterfly index) -> addr_a, addr_b, k (twiddle exponent).
module fft_addr_gen #(
  parameter int LOGN = 3,
  parameter int KW   = 2,
  parameter int BW   = 2
) (
  input  logic [LOGN-1:0] s,
  input  logic [BW-1:0]   b,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [KW-1:0]   k
);
  import fft_pkg::*;

  bfly_addr_t r;
  logic       unused_hi;

  always_comb begin
    r = bfly_addr(32'(LOGN), 32'(s), 32'(b));
  end

  assign addr_a = r.a[LOGN-1:0];
  assign addr_b = r.b[LOGN-1:0];
  assign k      = r.k[KW-1:0];

  // Upper bits are always zero for in-range s/b.
  assign unused_hi = ^{r.a[31:LOGN], r.b[31:LOGN], r.k[31:KW]};

endmodule

// File: rtl/fft_bfly_sched.sv
// Radix-2 DIT FFT butterfly scheduler: FSM, stage/butterfly counters, write pipe.
// Ports: clk, rst_n, start, stall in; busy, done, stage, rd_*, tw_idx, wr_* out.
module fft_bfly_sched #(
  parameter int N        = 8,
  parameter int BFLY_LAT = 2,
  localparam int LOGN    = $clog2(N),
  localparam int AW      = LOGN,
  localparam int KW      = (LOGN > 1) ? LOGN - 1 : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr_a,
  output logic [AW-1:0]   rd_addr_b,
  output logic [KW-1:0]   tw_idx,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr_a,
  output logic [AW-1:0]   wr_addr_b
);
  import fft_pkg::*;

  localparam int BW = KW;
  localparam int L  = BFLY_LAT;

  sched_state_e    state_q, state_d;
  logic [LOGN-1:0] s_q, s_d;
  logic [BW-1:0]   b_q, b_d;

  logic [L-1:0]    vld_q, vld_d;
  logic [AW-1:0]   pa_q [L];
  logic [AW-1:0]   pa_d [L];
  logic [AW-1:0]   pb_q [L];
  logic [AW-1:0]   pb_d [L];

  logic [AW-1:0]   gen_a;
  logic [AW-1:0]   gen_b;
  logic [KW-1:0]   gen_k;
  logic            last_b;
  logic            last_s;
  logic            issue;
  logic            pipe_busy;

  fft_addr_gen #(
    .LOGN (LOGN),
    .KW   (KW),
    .BW   (BW)
  ) u_addr_gen (
    .s      (s_q),
    .b      (b_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .k      (gen_k)
  );

  assign last_b = (b_q == BW'(N / 2 - 1));
  assign last_s = (s_q == LOGN'(LOGN - 1));
  assign issue  = (state_q == RUN) && !stall;

  // The tail entry retires this cycle, so only the younger entries
  // keep the stage from being complete.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < L - 1; i++) begin
      pipe_busy = pipe_busy | vld_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_b) begin
            state_d = DRAIN;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!stall && !pipe_busy) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!stall) begin
          state_d = IDLE;
          s_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) && !stall;
    stage     = s_q;
    rd_en     = issue;
    rd_addr_a = issue ? gen_a : '0;
    rd_addr_b = issue ? gen_b : '0;
    tw_idx    = issue ? gen_k : '0;
    wr_en     = vld_q[L-1] && !stall;
    wr_addr_a = wr_en ? pa_q[L-1] : '0;
    wr_addr_b = wr_en ? pb_q[L-1] : '0;
  end

  always_comb begin
    vld_d = vld_q;
    pa_d  = pa_q;
    pb_d  = pb_q;
    if (!stall) begin
      for (int i = L - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        pa_d[i]  = pa_q[i-1];
        pb_d[i]  = pb_q[i-1];
      end
      vld_d[0] = issue;
      pa_d[0]  = rd_addr_a;
      pb_d[0]  = rd_addr_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      pa_q  <= pa_d;
      pb_q  <= pb_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Testbench for fft_bfly_sched: three configurations, trace model, FFT datapath.
// Expected traces come from a nested group/position enumeration of each stage.
module tb_fft_bfly_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start;
  logic [2:0] stall;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd_en;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] k;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
    logic [7:0] stage;
    logic       done;
    logic       busy;
  } obs_t;

  obs_t obs0, obs1, obs2;

  logic       d0_busy, d0_done, d0_rd, d0_wr;
  logic [2:0] d0_st, d0_ra, d0_rb, d0_wa, d0_wb;
  logic [1:0] d0_k;
  logic       d1_busy, d1_done, d1_rd, d1_wr;
  logic [1:0] d1_st, d1_ra, d1_rb, d1_wa, d1_wb;
  logic [0:0] d1_k;
  logic       d2_busy, d2_done, d2_rd, d2_wr;
  logic [0:0] d2_st, d2_ra, d2_rb, d2_wa, d2_wb;
  logic [0:0] d2_k;

  fft_bfly_sched #(.N(8), .BFLY_LAT(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stall(stall[0]),
    .busy(d0_busy), .done(d0_done), .stage(d0_st),
    .rd_en(d0_rd), .rd_addr_a(d0_ra), .rd_addr_b(d0_rb), .tw_idx(d0_k),
    .wr_en(d0_wr), .wr_addr_a(d0_wa), .wr_addr_b(d0_wb)
  );

  fft_bfly_sched #(.N(4), .BFLY_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stall(stall[1]),
    .busy(d1_busy), .done(d1_done), .stage(d1_st),
    .rd_en(d1_rd), .rd_addr_a(d1_ra), .rd_addr_b(d1_rb), .tw_idx(d1_k),
    .wr_en(d1_wr), .wr_addr_a(d1_wa), .wr_addr_b(d1_wb)
  );

  fft_bfly_sched #(.N(2), .BFLY_LAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .stall(stall[2]),
    .busy(d2_busy), .done(d2_done), .stage(d2_st),
    .rd_en(d2_rd), .rd_addr_a(d2_ra), .rd_addr_b(d2_rb), .tw_idx(d2_k),
    .wr_en(d2_wr), .wr_addr_a(d2_wa), .wr_addr_b(d2_wb)
  );

  assign obs0 = {d0_rd, 8'(d0_ra), 8'(d0_rb), 8'(d0_k), d0_wr,
                 8'(d0_wa), 8'(d0_wb), 8'(d0_st), d0_done, d0_busy};
  assign obs1 = {d1_rd, 8'(d1_ra), 8'(d1_rb), 8'(d1_k), d1_wr,
                 8'(d1_wa), 8'(d1_wb), 8'(d1_st), d1_done, d1_busy};
  assign obs2 = {d2_rd, 8'(d2_ra), 8'(d2_rb), 8'(d2_k), d2_wr,
                 8'(d2_wa), 8'(d2_wb), 8'(d2_st), d2_done, d2_busy};

  function automatic obs_t get_obs(input int idx);
    case (idx)
      0: return obs0;
      1: return obs1;
      default: return obs2;
    endcase
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int t,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, req);
    end
  endtask

  obs_t ex [64];
  int   tlen;

  // Expected per-active-cycle trace, index 1 = first cycle after start.
  task automatic build_model(input int n, input int lat);
    int logn, ps, span, idx, t, a;
    logn = $clog2(n);
    ps   = n / 2 + lat;
    tlen = logn * ps + 1;
    for (int i = 0; i < 64; i++) ex[i] = '0;
    for (int i = 1; i <= tlen; i++) begin
      ex[i].busy  = 1'b1;
      ex[i].stage = (i == tlen) ? 8'(logn - 1) : 8'((i - 1) / ps);
    end
    ex[tlen].done = 1'b1;
    for (int s = 0; s < logn; s++) begin
      span = 1 << s;
      idx  = 0;
      for (int g = 0; g < n / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          t = 1 + s * ps + idx;
          a = g * 2 * span + p;
          ex[t].rd_en = 1'b1;
          ex[t].ra    = 8'(a);
          ex[t].rb    = 8'(a + span);
          ex[t].k     = 8'(p * (n / (2 * span)));
          ex[t+lat].wr_en = 1'b1;
          ex[t+lat].wa    = 8'(a);
          ex[t+lat].wb    = 8'(a + span);
          idx++;
        end
      end
    end
  endtask

  task automatic run(input int idx, input int n, input int lat,
                     input int st_at, input int st_len, input bit st_rnd,
                     input int xstart_at, output int done_cyc);
    int   t, cyc, stl_cnt;
    logic stl;
    obs_t ev;
    build_model(n, lat);
    done_cyc = -1;
    @(posedge clk); #1 start[idx] = 1'b1;
    @(posedge clk); #1 start[idx] = 1'b0;
    t = 1;
    cyc = 0;
    stl_cnt = 0;
    while (t <= tlen && cyc < 300) begin
      cyc++;
      stl = 1'b0;
      if (st_rnd) begin
        stl = ($urandom_range(0, 3) == 0);
      end else if (t >= st_at && stl_cnt < st_len) begin
        stl = 1'b1;
        stl_cnt++;
      end
      stall[idx] = stl;
      start[idx] = (t == xstart_at);
      @(negedge clk);
      if (stl) begin
        ev = '0;
        ev.busy  = 1'b1;
        ev.stage = ex[t].stage;
      end else begin
        ev = ex[t];
      end
      if (get_obs(idx).done) done_cyc = cyc;
      check("trace", t, get_obs(idx), ev);
      if (!stl) t++;
      @(posedge clk); #1;
    end
    stall[idx] = 1'b0;
    start[idx] = 1'b0;
    check("complete", t, t, tlen + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after", i, get_obs(idx), '0);
    end
  endtask

  real rre [8];
  real rim [8];
  real qtr [$];
  real qti [$];
  real qbr [$];
  real qbi [$];
  bit  e2e = 1'b0;

  // RAM + butterfly driven by DUT0 strobes.
  always @(negedge clk) begin
    real ar, ai, br, bi, wr, wi, pr, pi, ang;
    if (e2e) begin
      if (obs0.wr_en && qtr.size() > 0) begin
        rre[obs0.wa[2:0]] = qtr.pop_front();
        rim[obs0.wa[2:0]] = qti.pop_front();
        rre[obs0.wb[2:0]] = qbr.pop_front();
        rim[obs0.wb[2:0]] = qbi.pop_front();
      end
      if (obs0.rd_en) begin
        ar  = rre[obs0.ra[2:0]];
        ai  = rim[obs0.ra[2:0]];
        br  = rre[obs0.rb[2:0]];
        bi  = rim[obs0.rb[2:0]];
        ang = 2.0 * 3.14159265358979 * real'(obs0.k) / 8.0;
        wr  = $cos(ang);
        wi  = -$sin(ang);
        pr  = wr * br - wi * bi;
        pi  = wr * bi + wi * br;
        qtr.push_back(ar + pr);
        qti.push_back(ai + pi);
        qbr.push_back(ar - pr);
        qbi.push_back(ai - pi);
      end
    end
  end

  typedef struct {
    string name;
    int    idx;
    int    n;
    int    lat;
    int    st_at;
    int    st_len;
    int    xstart;
    int    exp_cyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int dc;
    vecs[0] = '{"n8_plain",  0, 8, 2, 0, 0, 0, 19};
    vecs[1] = '{"n4_plain",  1, 4, 2, 0, 0, 0, 9};
    vecs[2] = '{"n2_lat1",   2, 2, 1, 0, 0, 0, 3};
    vecs[3] = '{"n8_stall3", 0, 8, 2, 9, 3, 0, 22};
    vecs[4] = '{"n8_xstart", 0, 8, 2, 0, 0, 5, 19};

    rst_n = 1'b0;
    start = '0;
    stall = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("reset_state", i, get_obs(i), '0);
    @(negedge clk) rst_n = 1'b1;

    // Stall while idle must not block acceptance.
    @(posedge clk); #1 stall[1] = 1'b1; start[1] = 1'b1;
    @(posedge clk); #1 stall[1] = 1'b0; start[1] = 1'b0;
    @(negedge clk);
    check("idle_stall_start", 0, 64'(get_obs(1).busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run(vecs[v].idx, vecs[v].n, vecs[v].lat, vecs[v].st_at,
          vecs[v].st_len, 1'b0, vecs[v].xstart, dc);
      check(vecs[v].name, v, 64'(dc), 64'(vecs[v].exp_cyc));
    end

    // Asynchronous abort mid-run.
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("busy_before_abort", 0, 64'(obs0.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 0, obs0, '0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", i, obs0, '0);
    end
    run(0, 8, 2, 0, 0, 1'b0, 0, dc);
    check("after_abort", 0, 64'(dc), 64'd19);

    // Randomized stall patterns on every configuration.
    for (int r = 0; r < 3; r++) begin
      run(0, 8, 2, 0, 0, 1'b1, $urandom_range(1, 12), dc);
      run(1, 4, 2, 0, 0, 1'b1, 0, dc);
      run(2, 2, 1, 0, 0, 1'b1, 0, dc);
    end

    // Impulse at x[0] -> flat spectrum.
    for (int i = 0; i < 8; i++) begin
      rre[i] = 0.0;
      rim[i] = 0.0;
    end
    rre[0] = 100.0;
    qtr.delete(); qti.delete(); qbr.delete(); qbi.delete();
    e2e = 1'b1;
    run(0, 8, 2, 0, 0, 1'b1, 0, dc);
    e2e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("e2e_re", i, 64'($rtoi(rre[i] + 1000.5) - 1000), 64'd100);
      check("e2e_im", i, 64'($rtoi(rim[i] + 1000.5) - 1000), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
